// File: rtl/gate_tb_pkg.sv
// Shared constants for the 2-input gate sweep checker: truth tables indexed by {a,b}
// and the sweep FSM state encoding.
package gate_tb_pkg;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_e;

endpackage

// File: rtl/andgate.sv
// Combinational 2-input AND gate; the reference device exercised by the sweep checker.
module andgate (
    input  logic a,
    input  logic b,
    output logic c
);

    assign c = a & b;

endmodule

// File: rtl/hold_timer.sv
// Counts the cycles a vector is held; tick marks the last hold cycle, then the count wraps.
module hold_timer #(
    parameter int HOLD_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] r_count;

    assign tick = (r_count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// Drives a/b through 00,01,10,11, samples the gate output c at the end of each hold
// and accumulates a fail mask, error count and pass flag. No combinational path from c.
module gate_sweep_checker
    import gate_tb_pkg::*;
#(
    parameter int         HOLD_CYCLES = 5,
    parameter logic [3:0] EXPECT      = TT_AND
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         a,
    output logic         b,
    input  logic         c,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [2:0]   err_count,
    output logic [3:0]   fail_mask,
    output logic [1:0]   vec_idx,
    output sweep_state_e dbg_state
);

    // Handshake: start is a level sampled only in IDLE; done is a one-cycle pulse
    // coincident with busy falling, and results are stable from that cycle on.
    sweep_state_e r_state;
    sweep_state_e w_next_state;
    logic [1:0]   r_vec;
    logic         r_done;
    logic         r_pass;
    logic [2:0]   r_err_count;
    logic [3:0]   r_fail_mask;
    logic         w_tick;
    logic         w_start_sweep;
    logic         w_finish;
    logic         w_sample;
    logic         w_mismatch;

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(r_state == IDLE),
        .tick (w_tick)
    );

    always_comb begin
        w_next_state  = r_state;
        w_start_sweep = 1'b0;
        w_finish      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state  = SWEEP;
                    w_start_sweep = 1'b1;
                end
            end
            SWEEP: begin
                if (w_tick && (r_vec == 2'd3)) begin
                    w_next_state = IDLE;
                    w_finish     = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_sample = (r_state == SWEEP) && w_tick;
    // Case inequality so an unknown gate output counts as a failure.
    assign w_mismatch = (c !== EXPECT[r_vec]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_vec       <= 2'd0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= 3'd0;
            r_fail_mask <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_finish;
            if (w_start_sweep) begin
                r_vec       <= 2'd0;
                r_pass      <= 1'b0;
                r_err_count <= 3'd0;
                r_fail_mask <= 4'd0;
            end else if (w_sample) begin
                if (w_mismatch) begin
                    r_fail_mask[r_vec] <= 1'b1;
                    r_err_count        <= r_err_count + 3'd1;
                end
                if (r_vec == 2'd3) begin
                    r_vec  <= 2'd0;
                    r_pass <= (r_err_count == 3'd0) && !w_mismatch;
                end else begin
                    r_vec <= r_vec + 2'd1;
                end
            end
        end
    end

    // r_vec is forced back to 0 whenever the sweep ends, so a/b are 0 in IDLE.
    assign a         = r_vec[1];
    assign b         = r_vec[0];
    assign busy      = (r_state == SWEEP);
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign fail_mask = r_fail_mask;
    assign vec_idx   = r_vec;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: AND and OR expectations at H=5, back-to-back
// sweeps at H=1, X injection, mid-sweep start and mid-sweep reset.
module tb_gate_sweep_checker;
    import gate_tb_pkg::*;

    typedef struct {
        int         offset;
        logic       exp_a;
        logic       exp_b;
        logic       exp_busy;
        logic       exp_done;
        logic [1:0] exp_vec;
    } row_t;

    int n_checks = 0;
    int n_errors = 0;

    logic clk = 1'b0;
    logic rst;
    logic start_ab;
    logic start_h1;
    logic x_en;
    logic x_val;

    // AND-expect DUT, H=5
    logic a_and, b_and, c_and, g_and, busy_and, done_and, pass_and;
    logic [2:0] err_and;
    logic [3:0] mask_and;
    logic [1:0] vec_and;
    sweep_state_e st_and;
    // OR-expect DUT, H=5
    logic a_or, b_or, c_or, busy_or, done_or, pass_or;
    logic [2:0] err_or;
    logic [3:0] mask_or;
    logic [1:0] vec_or;
    sweep_state_e st_or;
    // AND-expect DUT, H=1
    logic a_h1, b_h1, c_h1, busy_h1, done_h1, pass_h1;
    logic [2:0] err_h1;
    logic [3:0] mask_h1;
    logic [1:0] vec_h1;
    sweep_state_e st_h1;

    row_t sweep_tbl[10];
    row_t h1_tbl[11];

    always #5 clk = ~clk;

    andgate g0 (.a(a_and), .b(b_and), .c(g_and));
    andgate g1 (.a(a_or),  .b(b_or),  .c(c_or));
    andgate g2 (.a(a_h1),  .b(b_h1),  .c(c_h1));

    assign c_and = x_en ? x_val : g_and;

    gate_sweep_checker #(.HOLD_CYCLES(5), .EXPECT(TT_AND)) u_and (
        .clk(clk), .rst(rst), .start(start_ab), .a(a_and), .b(b_and), .c(c_and),
        .busy(busy_and), .done(done_and), .pass(pass_and), .err_count(err_and),
        .fail_mask(mask_and), .vec_idx(vec_and), .dbg_state(st_and)
    );

    gate_sweep_checker #(.HOLD_CYCLES(5), .EXPECT(TT_OR)) u_or (
        .clk(clk), .rst(rst), .start(start_ab), .a(a_or), .b(b_or), .c(c_or),
        .busy(busy_or), .done(done_or), .pass(pass_or), .err_count(err_or),
        .fail_mask(mask_or), .vec_idx(vec_or), .dbg_state(st_or)
    );

    gate_sweep_checker #(.HOLD_CYCLES(1), .EXPECT(TT_AND)) u_h1 (
        .clk(clk), .rst(rst), .start(start_h1), .a(a_h1), .b(b_h1), .c(c_h1),
        .busy(busy_h1), .done(done_h1), .pass(pass_h1), .err_count(err_h1),
        .fail_mask(mask_h1), .vec_idx(vec_h1), .dbg_state(st_h1)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_row(input string name, input row_t r, input logic a_i, input logic b_i,
                             input logic busy_i, input logic done_i, input logic [1:0] vec_i);
        check(name, {10'd0, a_i, b_i, busy_i, done_i, vec_i},
              {10'd0, r.exp_a, r.exp_b, r.exp_busy, r.exp_done, r.exp_vec});
    endtask

    task automatic check_results(input string name, input logic pass_i, input logic [2:0] err_i,
                                 input logic [3:0] mask_i, input logic exp_pass,
                                 input logic [2:0] exp_err, input logic [3:0] exp_mask);
        check(name, {8'd0, pass_i, err_i, mask_i}, {8'd0, exp_pass, exp_err, exp_mask});
    endtask

    task automatic fill_tables();
        sweep_tbl[0] = '{0,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        sweep_tbl[1] = '{4,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        sweep_tbl[2] = '{5,  1'b0, 1'b1, 1'b1, 1'b0, 2'd1};
        sweep_tbl[3] = '{9,  1'b0, 1'b1, 1'b1, 1'b0, 2'd1};
        sweep_tbl[4] = '{10, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2};
        sweep_tbl[5] = '{14, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2};
        sweep_tbl[6] = '{15, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3};
        sweep_tbl[7] = '{19, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3};
        sweep_tbl[8] = '{20, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
        sweep_tbl[9] = '{21, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        // Two H=1 sweeps back to back: done at offsets 4 and 9, busy low only there and after.
        h1_tbl[0]  = '{0,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        h1_tbl[1]  = '{1,  1'b0, 1'b1, 1'b1, 1'b0, 2'd1};
        h1_tbl[2]  = '{2,  1'b1, 1'b0, 1'b1, 1'b0, 2'd2};
        h1_tbl[3]  = '{3,  1'b1, 1'b1, 1'b1, 1'b0, 2'd3};
        h1_tbl[4]  = '{4,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
        h1_tbl[5]  = '{5,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        h1_tbl[6]  = '{6,  1'b0, 1'b1, 1'b1, 1'b0, 2'd1};
        h1_tbl[7]  = '{7,  1'b1, 1'b0, 1'b1, 1'b0, 2'd2};
        h1_tbl[8]  = '{8,  1'b1, 1'b1, 1'b1, 1'b0, 2'd3};
        h1_tbl[9]  = '{9,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
        h1_tbl[10] = '{10, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    endtask

    // Sweeps u_and and u_or together; returns at the negedge after offset 21.
    task automatic run_ab_sweep(input string tag, input bit repulse, input bit inject_x);
        int  ti;
        bit  x_mis;
        x_mis = inject_x && (x_val !== 1'b1);
        @(negedge clk);
        start_ab = 1'b1;
        @(negedge clk);
        start_ab = 1'b0;
        ti = 0;
        for (int n = 0; n <= 21; n++) begin
            start_ab = repulse && (n == 2);
            if (inject_x) x_en = (n >= 15) && (n < 20);
            if (ti < 10 && sweep_tbl[ti].offset == n) begin
                check_row($sformatf("%s_and_t%0d", tag, n), sweep_tbl[ti],
                          a_and, b_and, busy_and, done_and, vec_and);
                check_row($sformatf("%s_or_t%0d", tag, n), sweep_tbl[ti],
                          a_or, b_or, busy_or, done_or, vec_or);
                ti++;
            end
            if (n == 20 || n == 21) begin
                check_results($sformatf("%s_and_res_t%0d", tag, n), pass_and, err_and, mask_and,
                              !x_mis, x_mis ? 3'd1 : 3'd0, x_mis ? 4'b1000 : 4'b0000);
                check_results($sformatf("%s_or_res_t%0d", tag, n), pass_or, err_or, mask_or,
                              1'b0, 3'd2, 4'b0110);
            end
            @(negedge clk);
        end
        x_en     = 1'b0;
        start_ab = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen_done;
        fill_tables();
        rst      = 1'b1;
        start_ab = 1'b0;
        start_h1 = 1'b0;
        x_en     = 1'b0;
        x_val    = 1'bx;
        repeat (3) @(negedge clk);
        check("reset_and", {1'b0, st_and, a_and, b_and, busy_and, done_and, pass_and, err_and, mask_and, vec_and}, 16'd0);
        check("reset_or",  {1'b0, st_or,  a_or,  b_or,  busy_or,  done_or,  pass_or,  err_or,  mask_or,  vec_or},  16'd0);
        check("reset_h1",  {1'b0, st_h1,  a_h1,  b_h1,  busy_h1,  done_h1,  pass_h1,  err_h1,  mask_h1,  vec_h1},  16'd0);
        rst = 1'b0;

        run_ab_sweep("basic", 1'b0, 1'b0);

        // start held high across ten edges at H=1
        @(negedge clk);
        start_h1 = 1'b1;
        @(negedge clk);
        for (int n = 0; n <= 10; n++) begin
            check_row($sformatf("h1_t%0d", n), h1_tbl[n], a_h1, b_h1, busy_h1, done_h1, vec_h1);
            if (n == 4 || n == 9)
                check_results($sformatf("h1_res_t%0d", n), pass_h1, err_h1, mask_h1, 1'b1, 3'd0, 4'b0000);
            if (n == 9) start_h1 = 1'b0;
            @(negedge clk);
        end

        run_ab_sweep("xinj", 1'b0, 1'b1);
        run_ab_sweep("repulse", 1'b1, 1'b0);

        // Reset asserted during vector 1 aborts the sweep without a done pulse.
        @(negedge clk);
        start_ab = 1'b1;
        @(negedge clk);
        start_ab = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_busy_before", {15'd0, busy_and}, 16'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_and", {1'b0, st_and, a_and, b_and, busy_and, done_and, pass_and, err_and, mask_and, vec_and}, 16'd0);
        check("abort_or",  {1'b0, st_or,  a_or,  b_or,  busy_or,  done_or,  pass_or,  err_or,  mask_or,  vec_or},  16'd0);
        seen_done = 0;
        for (int n = 0; n < 25; n++) begin
            if (done_and || done_or || busy_and) seen_done++;
            @(negedge clk);
        end
        check("abort_quiet", 16'(seen_done), 16'd0);

        run_ab_sweep("after_abort", 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Sequential stimulus-and-check stage for the 2-input gate blocks (`andgate` and its siblings). On a `start` pulse it drives `a`/`b` through the four input combinations 00, 01, 10, 11 and holds each for a programmable number of cycles. It samples the gate output `c` at the end of each hold and compares it against a parameterised truth table. It reports a per-vector fail mask, an error count and a pass flag, so gate checking moves from `$monitor` inspection to a self-checking clocked stage.

## Interface
Parameters:
- `HOLD_CYCLES`, default 5: cycles each vector is driven before `c` is sampled; legal range ≥ 1.
- `EXPECT`, default `4'b1000` (AND): expected `c` per vector; bit index = {a,b}.

Ports:
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: begin a sweep; sampled only in IDLE.
- `a` output, 1 bit: gate input A = `vec[1]`.
- `b` output, 1 bit: gate input B = `vec[0]`.
- `c` input, 1 bit: output of the gate under test.
- `busy` output, 1 bit: sweep in progress.
- `done` output, 1 bit: one-cycle pulse when the sweep completes.
- `pass` output, 1 bit: last sweep had zero mismatches.
- `err_count` output, 3 bits: mismatches in the current or last sweep, 0..4.
- `fail_mask` output, 4 bits: bit i is set if vector i mismatched.
- `vec_idx` output, 2 bits: vector currently driven.

## Operation
- States: IDLE and SWEEP.
- IDLE
  - `a`=`b`=0, `busy`=0.
  - `pass`, `err_count`, `fail_mask` hold the results of the last sweep.
- IDLE → SWEEP on an edge with `start`=1:
  - `vec`=0, hold count=0, `busy`=1.
  - `err_count`, `fail_mask`, `pass` are cleared to 0.
- SWEEP
  - `a`,`b` are driven from the registered `vec`.
  - The hold count increments each edge.
  - On the edge where count == `HOLD_CYCLES`-1, `c` is compared with `EXPECT[vec]`.
  - On a mismatch: set `fail_mask[vec]` and increment `err_count`.
  - The comparison uses case inequality, so X/Z on `c` is a mismatch.
- On that same edge:
  - If `vec` < 3: increment `vec` and reset the count to 0.
  - If `vec` == 3: go to IDLE, pulse `done`=1 for one cycle, and set `pass` = (final `err_count` == 0).
- `start` while in SWEEP is ignored; there is no restart and no queuing.
- `start` held high in IDLE re-arms immediately, so back-to-back sweeps start on the edge after `done`.
- Width rules:
  - Hold counter width is `$clog2(HOLD_CYCLES)` with a minimum of 1.
  - `err_count` saturates naturally at 4 and never wraps.

## Timing
- Reset value of all outputs is 0: `a`, `b`, `busy`, `done`, `pass`, `err_count`, `fail_mask`, `vec_idx`.
- `rst` asserted mid-sweep aborts the sweep at that edge: state goes to IDLE with reset values and no `done` pulse.
- `rst` has priority over `start` on the same edge.
- Vector schedule, with the start edge at k and H = `HOLD_CYCLES`:
  - vector i is driven from edge k+i·H;
  - vector i is sampled at edge k+(i+1)·H.
- At edge k+4H: `done`=1, `busy`=0, `pass` valid. `done` falls at edge k+4H+1.
- Total sweep latency is 4H cycles.
- With H=1, each vector lasts one cycle. The gate under test is combinational, so `c` is valid in the same cycle.
- `c` is sampled, never used combinationally; the block has no combinational path from `c` to any output.

## Structure
- Package `gate_tb_pkg`:
  - truth-table constants `TT_AND`=4'b1000, `TT_OR`=4'b1110, `TT_XOR`=4'b0110, `TT_NAND`=4'b0111;
  - state enum `sweep_state_e` {IDLE, SWEEP}.
- Sub-module `hold_timer`:
  - parameter `HOLD_CYCLES`; ports `clk`, `rst`, `clear`, `tick`;
  - `tick` is high on the last hold cycle.
  - Instantiated once.
- The top level `gate_sweep_checker` instantiates `andgate` only in the test bench, never inside itself.

## Test plan
- Defaults, with `andgate` connected, `start` pulsed → a,b sequence 00, 01, 10, 11, each held 5 cycles; `done` at start+20; `pass`=1, `err_count`=0, `fail_mask`=0000.
- `EXPECT`=`TT_OR` with `andgate` connected → vectors 01 and 10 mismatch; `fail_mask`=0110, `err_count`=2, `pass`=0.
- `HOLD_CYCLES`=1 with `start` held high for 10 cycles → two consecutive sweeps; `done` pulses at start+4 and start+9; `busy` is low only during the `done` cycle.
- `rst` asserted at start+7 (vector 1) → next edge: all outputs 0; no `done` pulse; a fresh `start` completes normally.
- `c` forced to X for vector 3 → `fail_mask`=1000, `err_count`=1, `pass`=0.
- `start` re-pulsed at start+3 mid-sweep → ignored; the sweep still completes at start+20 with the correct results.
